// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited request issue, in-order response
// queue feeding decode, and redirect/interrupt flushes that drop stale responses.
module fetch_unit #(
  parameter logic [31:0] BOOT_VEC     = 32'h0,
  parameter int          INT_SRC_CNT  = 1,
  parameter logic [31:0] INT_VEC_BASE = 32'h100,
  parameter int          QUEUE_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [31:0]            mem_req_data,
  input  logic                   mem_resp_valid,
  output logic                   mem_resp_ready,
  input  logic [31:0]            mem_resp_data,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            inst_data,
  output logic [31:0]            inst_pc,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic [INT_SRC_CNT-1:0] ints,
  input  logic [INT_SRC_CNT-1:0] int_mask,
  input  logic                   int_enable_set,
  output logic                   int_taken,
  output logic [4:0]             int_cause,
  output logic [31:0]            int_epc
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH   = QUEUE_DEPTH[CW:0];
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   deliver_pc_q, deliver_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          ie_q, ie_d;

  logic [31:0]   qpc_q   [QUEUE_DEPTH];
  logic [31:0]   qdata_q [QUEUE_DEPTH];

  logic [INT_SRC_CNT-1:0] int_hits;
  logic [4:0]    int_idx;
  logic          int_take;
  logic          flush;
  logic [31:0]   target;
  logic [CW-1:0] live;
  logic [CW:0]   in_use;
  logic          req_fire;
  logic          resp_fire;
  logic          push;
  logic          pop;

  always_comb begin
    int_hits = ints & int_mask;
    int_idx  = '0;
    for (int i = INT_SRC_CNT - 1; i >= 0; i--) begin
      if (int_hits[i]) int_idx = 5'(i);
    end
    // A redirect in the same cycle defers the interrupt; it is re-evaluated next cycle.
    int_take = ie_q & (|int_hits) & ~redirect_valid;
    flush    = redirect_valid | int_take;
    target   = redirect_valid ? (redirect_pc & ~32'h3)
                              : INT_VEC_BASE + {25'b0, int_idx, 2'b00};

    live   = outstanding_q - drop_cnt_q;
    in_use = {1'b0, live} + {1'b0, count_q};

    mem_req_valid  = rst & (in_use < DEPTH) & ~flush;
    mem_req_data   = fetch_pc_q;
    mem_resp_ready = rst;
    inst_valid     = rst & (count_q != '0) & ~flush;
    inst_pc        = qpc_q[rd_ptr_q];
    inst_data      = qdata_q[rd_ptr_q];
    int_taken      = int_take;
    int_cause      = int_idx;
    int_epc        = deliver_pc_q;

    req_fire  = mem_req_valid & mem_req_ready;
    resp_fire = mem_resp_valid & mem_resp_ready;
    push      = resp_fire & ~flush & (drop_cnt_q == '0);
    pop       = inst_valid & inst_ready;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    deliver_pc_d  = deliver_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    ie_d          = ie_q;

    case ({req_fire, resp_fire})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE;
      2'b01:   outstanding_d = outstanding_q - CNT_ONE;
      default: outstanding_d = outstanding_q;
    endcase

    if (flush) begin
      // Everything still in flight, minus the response landing now, is stale.
      drop_cnt_d   = outstanding_q - CW'(resp_fire);
      fetch_pc_d   = target;
      resp_pc_d    = target;
      deliver_pc_d = target;
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_fire && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CNT_ONE;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        deliver_pc_d = inst_pc + 32'd4;
        rd_ptr_d     = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    if (int_take)            ie_d = 1'b0;
    else if (int_enable_set) ie_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= BOOT_VEC;
      deliver_pc_q  <= BOOT_VEC;
      resp_pc_q     <= BOOT_VEC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      ie_q          <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      deliver_pc_q  <= deliver_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      ie_q          <= ie_d;
    end
  end

  // Queue payload carries no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      qpc_q[wr_ptr_q]   <= resp_pc_q;
      qdata_q[wr_ptr_q] <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory with variable latency and a
// transaction-level model of fetch/delivery/flush/interrupt behaviour.
module tb_fetch_unit;

  localparam logic [31:0] BOOT   = 32'h1000;
  localparam int          NSRC   = 3;
  localparam logic [31:0] IVBASE = 32'h100;
  localparam int          QD     = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mem_req_valid, mem_req_ready;
  logic [31:0]     mem_req_data;
  logic            mem_resp_valid, mem_resp_ready;
  logic [31:0]     mem_resp_data;
  logic            inst_valid, inst_ready;
  logic [31:0]     inst_data, inst_pc;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic [NSRC-1:0] ints, int_mask;
  logic            int_enable_set;
  logic            int_taken;
  logic [4:0]      int_cause;
  logic [31:0]     int_epc;

  fetch_unit #(.BOOT_VEC(BOOT), .INT_SRC_CNT(NSRC), .INT_VEC_BASE(IVBASE), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ints(ints), .int_mask(int_mask), .int_enable_set(int_enable_set),
    .int_taken(int_taken), .int_cause(int_cause), .int_epc(int_epc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // stimulus knobs
  logic            s_redir, s_ies, s_iready, s_qready;
  logic [31:0]     s_rpc;
  logic [NSRC-1:0] s_ints, s_mask;
  int              lat_min, lat_max, resp_pct;

  // reference model
  logic [31:0] m_fetch_pc, m_deliver_pc;
  logic        m_ie;
  logic [31:0] mem_addr [$];
  int          mem_due  [$];
  bit          mem_stale[$];
  logic [31:0] iq_pc    [$];
  logic [31:0] iq_data  [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fetch_pc   = BOOT;
    m_deliver_pc = BOOT;
    m_ie         = 1'b0;
    mem_addr.delete(); mem_due.delete(); mem_stale.delete();
    iq_pc.delete(); iq_data.delete();
  endtask

  task automatic do_reset();
    mem_resp_valid = 1'b0; mem_resp_data = '0; redirect_valid = 1'b0;
    int_enable_set = 1'b0; ints = '0;
    rst = 1'b0;
    #1;
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_resp_ready", mem_resp_ready, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_int_taken", int_taken, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic step();
    bit          rv, take, fl, found, exp_req, exp_iv;
    int          cause, live;
    logic [31:0] tgt;
    logic [NSRC-1:0] hits;
    @(negedge clk);
    redirect_valid = s_redir;  redirect_pc    = s_rpc;
    ints           = s_ints;   int_mask       = s_mask;
    int_enable_set = s_ies;    inst_ready     = s_iready;
    mem_req_ready  = s_qready;
    rv = (mem_addr.size() > 0) && (mem_due[0] <= cyc) && ($urandom_range(99) < resp_pct);
    mem_resp_valid = rv;
    mem_resp_data  = rv ? mem_word(mem_addr[0]) : 32'h0;
    #1;
    hits  = s_ints & s_mask;
    found = 1'b0;
    cause = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (!found && hits[i]) begin cause = i; found = 1'b1; end
    end
    take = m_ie && found && !s_redir;
    fl   = s_redir || take;
    tgt  = s_redir ? (s_rpc & 32'hFFFF_FFFC) : IVBASE + 32'(4 * cause);
    live = 0;
    foreach (mem_stale[i]) if (!mem_stale[i]) live++;
    exp_req = (live + iq_pc.size() < QD) && !fl;
    exp_iv  = (iq_pc.size() > 0) && !fl;

    check("req_valid", mem_req_valid, exp_req);
    if (exp_req) check("req_addr", mem_req_data, m_fetch_pc);
    check("resp_ready", mem_resp_ready, 1);
    check("inst_valid", inst_valid, exp_iv);
    if (exp_iv) begin
      check("inst_pc", inst_pc, iq_pc[0]);
      check("inst_data", inst_data, iq_data[0]);
    end
    check("int_taken", int_taken, take);
    if (take) begin
      check("int_cause", int_cause, cause);
      check("int_epc", int_epc, m_deliver_pc);
    end

    if (rv) begin
      if (!mem_stale[0] && !fl) begin
        iq_pc.push_back(mem_addr[0]);
        iq_data.push_back(mem_word(mem_addr[0]));
      end
      void'(mem_addr.pop_front()); void'(mem_due.pop_front()); void'(mem_stale.pop_front());
    end
    if (fl) begin
      foreach (mem_stale[i]) mem_stale[i] = 1'b1;
      iq_pc.delete(); iq_data.delete();
      m_fetch_pc   = tgt;
      m_deliver_pc = tgt;
    end else begin
      if (exp_iv && s_iready) begin
        m_deliver_pc = iq_pc[0] + 32'd4;
        void'(iq_pc.pop_front()); void'(iq_data.pop_front());
      end
      if (exp_req && s_qready) begin
        mem_addr.push_back(m_fetch_pc);
        mem_due.push_back(cyc + $urandom_range(lat_max, lat_min));
        mem_stale.push_back(1'b0);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    if (take) m_ie = 1'b0;
    else if (s_ies) m_ie = 1'b1;
    cyc++;
  endtask

  task automatic quiet();
    s_redir = 0; s_rpc = '0; s_ints = '0; s_mask = 3'b111; s_ies = 0;
    s_iready = 1; s_qready = 1;
  endtask

  initial begin
    quiet();
    lat_min = 1; lat_max = 1; resp_pct = 100;
    mem_req_ready = 1'b1; inst_ready = 1'b1; redirect_pc = '0; int_mask = '1;
    #1 do_reset();

    // streaming, single-cycle memory
    repeat (30) step();

    // backpressure, then release
    s_iready = 0;
    repeat (12) step();
    s_iready = 1;
    repeat (10) step();

    // redirect with responses in flight at latency 5
    lat_min = 5; lat_max = 5;
    repeat (4) step();
    s_redir = 1; s_rpc = 32'h2002;
    step();
    s_redir = 0;
    repeat (20) step();
    lat_min = 1; lat_max = 3;

    // interrupt: enable, take once, no retake until re-enabled
    s_ies = 1; step(); s_ies = 0;
    s_ints = 3'b110; s_mask = 3'b111;
    repeat (8) step();
    s_ies = 1; step(); s_ies = 0;
    repeat (3) step();
    s_ints = '0;
    repeat (6) step();

    // redirect and interrupt in the same cycle
    s_ies = 1; step(); s_ies = 0;
    s_ints = 3'b110; s_redir = 1; s_rpc = 32'h3000;
    step();
    s_redir = 0;
    repeat (3) step();
    s_ints = '0;
    repeat (6) step();

    // async reset between edges, mid-stream
    repeat (5) step();
    #2 do_reset();
    repeat (10) step();

    // random traffic
    lat_min = 1; lat_max = 6; resp_pct = 75;
    repeat (3000) begin
      s_redir  = ($urandom_range(99) < 4);
      s_rpc    = $urandom;
      s_ints   = ($urandom_range(9) == 0) ? NSRC'($urandom) : '0;
      s_mask   = ($urandom_range(3) == 0) ? NSRC'($urandom) : '1;
      s_ies    = ($urandom_range(99) < 5);
      s_iready = ($urandom_range(99) < 70);
      s_qready = ($urandom_range(99) < 80);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
